// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI frame sequencer driving CSn/SCK/SDO and sampling SDI.
// Define SPI_LOOPBACK_EN to add a Loopback input that samples SDO internally.
module spi_xfer_ctrl (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [11:0] SckDiv,
  input  logic [1:0]  SckMode,
  input  logic [1:0]  CsMode,
  input  logic [3:0]  FmtLen,
  input  logic        FmtEndian,
  input  logic [7:0]  CsSck,
  input  logic [7:0]  SckCs,
  input  logic [7:0]  InterCs,
  input  logic        TxValid,
  input  logic [7:0]  TxData,
  output logic        TxReady,
  output logic        RxValid,
  output logic [7:0]  RxData,
  output logic        SCK,
  output logic        CSn,
  output logic        SDO,
  input  logic        SDI,
`ifdef SPI_LOOPBACK_EN
  input  logic        Loopback,
`endif
  output logic        Busy
);

  typedef enum logic [2:0] {
    IDLE, CSSCK, XFER, SCKCS, INTERCS
  } state_t;

  state_t state_q, state_d;

  logic [11:0] div_q, cnt_q, div_n;
  logic [8:0]  half_q;
  logic [7:0]  dly_q, tx_q, rx_q;
  logic [7:0]  rx_nxt, rx_fin, ord, rxd_q;
  logic [3:0]  len_q, len_n;
  logic        pha_q, lsb_q, auto_q;
  logic        sck_q, csn_q, sdo_q, rxv_q;
  logic        tick, lead, sin;
  logic        wait_done, xfer_last;
  logic        release_cs, pop;
  logic        cs_set, cs_clr;
  logic        shift_en, sample_en, rx_done;

  assign tick = (cnt_q == 12'd0);
  assign lead = ~half_q[0];
  assign len_n = (FmtLen == 4'd0 || FmtLen > 4'd8)
               ? 4'd8 : FmtLen;
  assign div_n = pop ? SckDiv : div_q;

  assign release_cs = (state_q == IDLE) && !csn_q
                   && (CsMode != 2'd2);
  // Hold off a pop in the cycle the previous frame is pushed.
  assign pop = (state_q == IDLE) && TxValid
            && !release_cs && !rxv_q;

  assign wait_done = (dly_q == 8'd0)
    || (tick && half_q == {dly_q, 1'b0} - 9'd1);
  assign xfer_last = tick
    && (half_q == {4'd0, len_q, 1'b0} - 9'd1);

`ifdef SPI_LOOPBACK_EN
  assign sin = Loopback ? sdo_q : SDI;
`else
  assign sin = SDI;
`endif

  // Reorder so the first bit on the wire is always bit 7.
  always_comb begin
    ord = TxData;
    if (FmtEndian)
      for (int i = 0; i < 8; i++) ord[i] = TxData[7-i];
  end

  assign rx_nxt = lsb_q ? {sin, rx_q[7:1]}
                        : {rx_q[6:0], sin};
  assign rx_fin = sample_en ? rx_nxt : rx_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (release_cs)
          state_d = INTERCS;
        else if (pop)
          state_d = (!csn_q || CsMode == 2'd3)
                  ? XFER : CSSCK;
      end
      CSSCK:   if (wait_done) state_d = XFER;
      XFER:    if (xfer_last)
                 state_d = auto_q ? SCKCS : IDLE;
      SCKCS:   if (wait_done) state_d = INTERCS;
      INTERCS: if (wait_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TxReady   = pop && PRESETn;
    cs_set    = pop && csn_q && (CsMode != 2'd3);
    cs_clr    = release_cs
             || (state_q == SCKCS && wait_done);
    shift_en  = 1'b0;
    sample_en = 1'b0;
    rx_done   = 1'b0;
    if (state_q == XFER && tick) begin
      sample_en = lead ^ pha_q;
      shift_en  = ~(lead ^ pha_q);
      rx_done   = xfer_last;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      div_q  <= '0;
      cnt_q  <= '0;
      half_q <= '0;
      dly_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      rxd_q  <= '0;
      len_q  <= 4'd8;
      pha_q  <= 1'b0;
      lsb_q  <= 1'b0;
      auto_q <= 1'b1;
      sck_q  <= 1'b0;
      csn_q  <= 1'b1;
      sdo_q  <= 1'b0;
      rxv_q  <= 1'b0;
    end else begin
      rxv_q <= rx_done;
      if (state_d != state_q) begin
        cnt_q  <= div_n;
        half_q <= '0;
      end else if (tick) begin
        cnt_q  <= div_q;
        half_q <= half_q + 9'd1;
      end else begin
        cnt_q <= cnt_q - 12'd1;
      end
      if (state_d != state_q) begin
        case (state_d)
          CSSCK:   dly_q <= CsSck;
          SCKCS:   dly_q <= SckCs;
          INTERCS: dly_q <= InterCs;
          default: dly_q <= dly_q;
        endcase
      end
      if (state_q == IDLE)
        sck_q <= SckMode[1];
      else if (state_q == XFER && tick)
        sck_q <= ~sck_q;
      if (cs_set)      csn_q <= 1'b0;
      else if (cs_clr) csn_q <= 1'b1;
      if (pop) begin
        div_q  <= SckDiv;
        pha_q  <= SckMode[0];
        len_q  <= len_n;
        lsb_q  <= FmtEndian;
        auto_q <= ~CsMode[1];
        rx_q   <= '0;
        if (SckMode[0]) begin
          tx_q <= ord;
        end else begin
          tx_q  <= {ord[6:0], 1'b0};
          sdo_q <= ord[7];
        end
      end else begin
        if (shift_en) begin
          sdo_q <= tx_q[7];
          tx_q  <= {tx_q[6:0], 1'b0};
        end
        if (sample_en) rx_q <= rx_nxt;
      end
      if (rx_done)
        rxd_q <= lsb_q ? rx_fin >> (4'd8 - len_q)
                       : rx_fin;
    end
  end

  assign RxValid = rxv_q;
  assign RxData  = rxd_q;
  assign SCK     = sck_q;
  assign CSn     = csn_q;
  assign SDO     = sdo_q;
  assign Busy    = (state_q != IDLE) || !csn_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed and random frames checked against
// a cycle-count model of the SPI sequencer timing rules.
module tb_spi_xfer_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [11:0] SckDiv;
  logic [1:0]  SckMode, CsMode;
  logic [3:0]  FmtLen;
  logic        FmtEndian;
  logic [7:0]  CsSck, SckCs, InterCs, TxData, RxData;
  logic        TxValid, TxReady, RxValid;
  logic        SCK, CSn, SDO, SDI, Busy;
  logic        lb, sdi_drv;

  int cyc, n_assert, n_fail;
  int last_rx, last_pop, last_rxd, last_sent;

  assign SDI = lb ? SDO : sdi_drv;

  spi_xfer_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .SckDiv(SckDiv), .SckMode(SckMode),
    .CsMode(CsMode), .FmtLen(FmtLen),
    .FmtEndian(FmtEndian), .CsSck(CsSck),
    .SckCs(SckCs), .InterCs(InterCs),
    .TxValid(TxValid), .TxData(TxData),
    .TxReady(TxReady), .RxValid(RxValid),
    .RxData(RxData), .SCK(SCK), .CSn(CSn),
    .SDO(SDO), .SDI(SDI),
`ifdef SPI_LOOPBACK_EN
    .Loopback(1'b0),
`endif
    .Busy(Busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int wcyc(input int n, input int d);
    return (n == 0) ? 1 : n * 2 * d;
  endfunction

  task automatic run_frame(
    input int div, input int mode, input int csm,
    input int lenr, input int endn, input int css,
    input int scs, input int ics,
    input logic [7:0] data, input logic lp,
    input logic [7:0] rbits, input int pre);
    int d, L, pop, entry, first, last, ne, k;
    int rxc, nrx, csfall, csrise, idle, lowc;
    logic held, pha, pol, auto_m, off_m;
    logic psck, psdo, inb;
    logic [7:0] sent, esent, erx, rxd;
    d = div + 1;
    L = (lenr == 0 || lenr > 8) ? 8 : lenr;
    pha = (mode & 1) != 0;
    pol = (mode & 2) != 0;
    auto_m = csm <= 1;
    off_m = csm == 3;
    SckDiv = 12'(div);
    SckMode = 2'(mode);
    CsMode = 2'(csm);
    FmtLen = 4'(lenr);
    FmtEndian = endn[0];
    CsSck = 8'(css);
    SckCs = 8'(scs);
    InterCs = 8'(ics);
    TxData = data;
    lb = lp;
    sdi_drv = rbits[0];
    repeat (pre) @(negedge PCLK);
    if (pre >= 2) check("sck_idle", SCK, pol);
    held = (CSn === 1'b0);
    TxValid = 1'b1;
    pop = -1;
    for (int i = 0; i < 300 && pop < 0; i++) begin
      #1;
      if (TxReady === 1'b1) pop = cyc;
      else @(negedge PCLK);
    end
    check("pop_seen", pop >= 0, 1);
    if (pop < 0) begin
      TxValid = 1'b0;
      return;
    end
    psck = SCK; psdo = SDO;
    ne = 0; k = 0; nrx = 0;
    first = -1; last = -1; rxc = -1;
    csfall = -1; csrise = -1; idle = -1; lowc = 0;
    sent = '0; rxd = '0;
    for (int i = 0; i < 3000 && idle < 0; i++) begin
      @(negedge PCLK);
      if (i == 0) TxValid = 1'b0;
      if (SCK !== psck) begin
        ne++;
        if (first < 0) first = cyc;
        last = cyc;
        if (((ne % 2) == 1) != pha) begin
          if (k < 8) sent[k] = psdo;
          k++;
          sdi_drv = (k < 8) ? rbits[k] : 1'b0;
        end
      end
      psck = SCK; psdo = SDO;
      if (CSn === 1'b0) lowc++;
      if (CSn === 1'b0 && csfall < 0) csfall = cyc;
      if (CSn === 1'b1 && csfall >= 0 && csrise < 0)
        csrise = cyc;
      if (RxValid === 1'b1) begin
        nrx++; rxc = cyc; rxd = RxData;
      end
      if (nrx > 0 && (!auto_m || Busy === 1'b0))
        idle = cyc;
    end
    check("frame_done", idle >= 0, 1);
    esent = '0; erx = '0;
    for (int j = 0; j < L; j++) begin
      esent[j] = endn != 0 ? data[j] : data[7-j];
      inb = lp ? esent[j] : rbits[j];
      if (endn != 0) erx[j] = inb;
      else erx[L-1-j] = inb;
    end
    entry = (held || off_m) ? pop + 1
                            : pop + 1 + wcyc(css, d);
    check("first_edge", first, entry + d);
    check("edge_count", ne, 2 * L);
    check("last_edge", last, first + (2*L - 1) * d);
    check("sdo_bits", sent, esent);
    check("rx_cycle", rxc, last);
    check("rx_count", nrx, 1);
    check("rx_data", rxd, erx);
    check("sck_end", SCK, pol);
    if (auto_m) begin
      check("cs_fall", csfall, pop + 1);
      check("cs_rise", csrise, last + wcyc(scs, d));
      check("idle_at", idle, csrise + wcyc(ics, d));
      check("cs_low_len", lowc, csrise - csfall);
    end else if (off_m) begin
      check("cs_off_low", lowc, 0);
    end else begin
      check("cs_hold_low", lowc, idle - pop);
    end
    last_rx = rxc;
    last_pop = pop;
    last_rxd = int'(rxd);
    last_sent = int'(sent);
  endtask

  initial begin
    int prx, nrx, pop, t;
    PRESETn = 1'b0;
    TxValid = 1'b1;
    TxData = 8'h5A;
    SckDiv = '0; SckMode = 2'b10; CsMode = '0;
    FmtLen = 4'd8; FmtEndian = 1'b0;
    CsSck = '0; SckCs = '0; InterCs = '0;
    lb = 1'b0; sdi_drv = 1'b0;
    @(negedge PCLK);
    check("rst_txready", TxReady, 0);
    check("rst_rxvalid", RxValid, 0);
    check("rst_rxdata", RxData, 0);
    check("rst_sck", SCK, 0);
    check("rst_csn", CSn, 1);
    check("rst_sdo", SDO, 0);
    check("rst_busy", Busy, 0);
    TxValid = 1'b0;
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("sck_pol_after_rst", SCK, 1);

    run_frame(0, 0, 0, 8, 0, 0, 0, 0, 8'hA5, 1, 8'h00, 2);
    check("t1_rx_a5", last_rxd, 32'hA5);
    check("t1_sdo_a5", last_sent, 32'hA5);

    run_frame(3, 3, 0, 5, 1, 0, 0, 0, 8'h96, 0, 8'hFF, 2);
    check("t2_rx_1f", last_rxd, 32'h1F);

    run_frame(0, 0, 2, 8, 0, 0, 0, 0, 8'h12, 1, 8'h00, 2);
    check("hold_rx1", last_rxd, 32'h12);
    prx = last_rx;
    run_frame(0, 0, 2, 8, 0, 0, 0, 0, 8'h34, 1, 8'h00, 0);
    check("hold_pop_gap", last_pop, prx + 1);
    check("hold_rx2", last_rxd, 32'h34);
    check("hold_cs_low", CSn, 0);
    CsMode = 2'd0;
    @(negedge PCLK);
    check("cs_release", CSn, 1);
    check("busy_intercs", Busy, 1);
    @(negedge PCLK);
    check("busy_idle", Busy, 0);

    run_frame(0, 0, 3, 8, 0, 0, 0, 0, 8'hFF, 1, 8'h00, 2);
    check("off_rx_ff", last_rxd, 32'hFF);

    run_frame(1, 0, 0, 8, 0, 2, 1, 3, 8'h3C, 0,
              8'($urandom), 2);

    SckDiv = 12'd1; SckMode = 2'b00; CsMode = 2'd0;
    FmtLen = 4'd8; FmtEndian = 1'b0;
    CsSck = '0; SckCs = '0; InterCs = '0;
    TxData = 8'hFF;
    @(negedge PCLK);
    TxValid = 1'b1;
    pop = -1;
    for (int i = 0; i < 50 && pop < 0; i++) begin
      #1;
      if (TxReady === 1'b1) pop = cyc;
      else @(negedge PCLK);
    end
    check("rst_mid_pop", pop >= 0, 1);
    @(negedge PCLK);
    TxValid = 1'b0;
    nrx = 0;
    repeat (12) begin
      @(negedge PCLK);
      if (RxValid === 1'b1) nrx++;
    end
    check("mid_busy", Busy, 1);
    PRESETn = 1'b0;
    TxValid = 1'b1;
    #1;
    check("mid_rst_csn", CSn, 1);
    check("mid_rst_sck", SCK, 0);
    check("mid_rst_sdo", SDO, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_txready", TxReady, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    TxValid = 1'b0;
    PRESETn = 1'b1;
    repeat (20) begin
      @(negedge PCLK);
      if (RxValid === 1'b1) nrx++;
    end
    check("mid_rst_no_rx", nrx, 0);
    run_frame(1, 0, 0, 8, 0, 0, 0, 0, 8'hC3, 1, 8'h00, 2);
    check("post_rst_rx", last_rxd, 32'hC3);

    for (int r = 0; r < 10; r++) begin
      t = $urandom_range(0, 2);
      run_frame($urandom_range(0, 2), $urandom_range(0, 3),
                (t == 2) ? 3 : t, $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2),
                8'($urandom), 1'($urandom_range(0, 1)),
                8'($urandom), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
